lap_stopwatch: RTL and testbench

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/lap_stopwatch_if.sv | 32 +++
 rtl/lap_stopwatch.sv | 204 ++++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lap_stopwatch_if.sv
`default_nettype none
// ============================================================================
// Module      : lap_stopwatch_if
// Description : Pulse inputs and display/stash outputs of the lap stopwatch.
//               The slave modport is the stopwatch side, master the driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface lap_stopwatch_if #(
  parameter int DIGITS = 4,
  parameter int DEPTH  = 8
);
  logic                       trig;
  logic                       split;
  logic                       sample;
  logic                       next_sample;
  logic [4*DIGITS-1:0]        time_out;
  logic [4*DIGITS-1:0]        stash_out;
  logic [$clog2(DEPTH+1)-1:0] stash_cnt;
  logic                       running;
  logic                       frozen;

  modport slave (
    input  trig, split, sample, next_sample,
    output time_out, stash_out, stash_cnt, running, frozen
  );

  modport master (
    output trig, split, sample, next_sample,
    input  time_out, stash_out, stash_cnt, running, frozen
  );
endinterface
`default_nettype wire

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : lap_stopwatch
// Description : BCD stopwatch with split (frozen snapshot) display and a
//               circular stash of sampled times that can be browsed.
//               Optional macro LAP_STOPWATCH_LAP_DELTA_EN: stash stores the
//               lap time (live count minus previous push) instead of the
//               absolute count.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  lap_stopwatch_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PAUSED   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pre, pre_nxt;
  logic [W-1:0]    count, count_nxt, count_inc;
  logic [W-1:0]    snap, snap_nxt;
  logic            frozen_r, frozen_nxt;
  logic [W-1:0]    time_r;
  logic            running_r;
  logic            tick;

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, wr_nxt, old_ptr, old_nxt, sel_ptr, sel_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;
  logic [W-1:0]    stash_r, stash_nxt;
  logic [W-1:0]    push_val;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? PTR_LAST : p - AW'(1);
  endfunction

  assign tick = (state == COUNTING) && (pre == PRE_LAST);

  // Ripple BCD incrementer; all-nines naturally rolls over to all-zeros.
  logic [DIGITS:0] carry;
  assign carry[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_inc
    logic [3:0] dig;
    assign dig             = count[4*d +: 4];
    assign carry[d+1]      = carry[d] && (dig == 4'd9);
    assign count_inc[4*d +: 4] = !carry[d]      ? dig :
                                 (dig == 4'd9)  ? 4'd0 : dig + 4'd1;
  end

`ifdef LAP_STOPWATCH_LAP_DELTA_EN
  logic [W-1:0]    lap_ref;
  logic [W-1:0]    lap_delta;
  logic [DIGITS:0] borrow;
  assign borrow[0] = 1'b0;
  // Per-digit BCD subtract; the final borrow is dropped, giving mod 10^DIGITS.
  for (genvar d = 0; d < DIGITS; d++) begin : g_sub
    logic [4:0] diff;
    assign diff        = {1'b0, count[4*d +: 4]} - {1'b0, lap_ref[4*d +: 4]}
                         - {4'b0, borrow[d]};
    assign borrow[d+1] = diff[4];
    assign lap_delta[4*d +: 4] = diff[4] ? diff[3:0] + 4'd10 : diff[3:0];
  end
  assign push_val = lap_delta;

  // Lap reference: cleared on entry to IDLE, otherwise follows each push.
  always_ff @(posedge clk) begin
    if (!reset_n)
      lap_ref <= '0;
    else if (state != IDLE && state_nxt == IDLE)
      lap_ref <= '0;
    else if (bus.sample)
      lap_ref <= count;
  end
`else
  assign push_val = count;
`endif

  // Next-state logic for the FSM, prescaler, live count and split snapshot.
  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre;
    count_nxt  = count;
    snap_nxt   = snap;
    frozen_nxt = frozen_r;
    if (state == COUNTING) begin
      pre_nxt = tick ? '0 : pre + PW'(1);
      if (tick) count_nxt = count_inc;
    end
    case (state)
      IDLE: begin
        if (bus.trig) state_nxt = COUNTING;
      end
      COUNTING: begin
        if (bus.trig) begin
          state_nxt  = PAUSED;
          frozen_nxt = 1'b0;
        end else if (bus.split) begin
          snap_nxt   = count;
          frozen_nxt = 1'b1;
        end
      end
      PAUSED: begin
        if (bus.trig)       state_nxt = COUNTING;
        else if (bus.split) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) begin
      count_nxt = '0;
      pre_nxt   = '0;
    end
  end

  // State, count and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pre       <= '0;
      count     <= '0;
      snap      <= '0;
      frozen_r  <= 1'b0;
      time_r    <= '0;
      running_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      count     <= count_nxt;
      snap      <= snap_nxt;
      frozen_r  <= frozen_nxt;
      time_r    <= frozen_nxt ? snap_nxt : count_nxt;
      running_r <= (state_nxt == COUNTING);
    end
  end

  // Stash pointers: sample wins over browse; oldest only moves once full.
  always_comb begin
    wr_nxt  = wr_ptr;
    old_nxt = old_ptr;
    sel_nxt = sel_ptr;
    cnt_nxt = cnt_r;
    if (bus.sample) begin
      wr_nxt  = ptr_inc(wr_ptr);
      sel_nxt = wr_ptr;
      if (cnt_r == CNT_FULL) old_nxt = ptr_inc(old_ptr);
      else                   cnt_nxt = cnt_r + CW'(1);
    end else if (bus.next_sample && cnt_r != '0) begin
      sel_nxt = (sel_ptr == old_ptr) ? ptr_dec(wr_ptr) : ptr_dec(sel_ptr);
    end
    if (bus.sample)       stash_nxt = push_val;
    else if (cnt_r == '0) stash_nxt = '0;
    else                  stash_nxt = mem[sel_nxt];
  end

  // Stash bookkeeping and registered stash output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      old_ptr <= '0;
      sel_ptr <= '0;
      cnt_r   <= '0;
      stash_r <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      old_ptr <= old_nxt;
      sel_ptr <= sel_nxt;
      cnt_r   <= cnt_nxt;
      stash_r <= stash_nxt;
    end
  end

  // Stash storage; contents are never cleared, only hidden by the count.
  always_ff @(posedge clk) begin
    if (reset_n && bus.sample) mem[wr_ptr] <= push_val;
  end

  assign bus.time_out  = time_r;
  assign bus.stash_out = stash_r;
  assign bus.stash_cnt = cnt_r;
  assign bus.running   = running_r;
  assign bus.frozen    = frozen_r;

endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_stopwatch
// Description : Scoreboard bench for lap_stopwatch (DIGITS=2, DEPTH=3,
//               TICK_DIV=2). A decimal reference model predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_stopwatch;
  localparam int DIGITS   = 2;
  localparam int DEPTH    = 3;
  localparam int TICK_DIV = 2;
  localparam int W        = 4 * DIGITS;
  localparam int MOD      = 10 ** DIGITS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lap_stopwatch_if #(.DIGITS(DIGITS), .DEPTH(DEPTH)) bus ();

  lap_stopwatch #(.DIGITS(DIGITS), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [W-1:0] t;
    logic [W-1:0] s;
    int           c;
    bit           r;
    bit           f;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // model state: 0 idle, 1 counting, 2 paused; counts are plain decimals
  int   m_st = 0, m_pre = 0, m_cnt = 0, m_snap = 0, m_ref = 0, m_sel = 0;
  bit   m_frz = 0;
  int   m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit tr, input bit sp, input bit sa, input bit ns, input bit rn);
    int  ost, ocnt, v;
    bit  tk;
    exp_t e;
    if (!rn) begin
      m_st = 0; m_pre = 0; m_cnt = 0; m_snap = 0; m_frz = 0; m_ref = 0; m_sel = 0;
      m_q.delete();
    end else begin
      ost  = m_st;
      ocnt = m_cnt;
      tk   = (ost == 1) && (m_pre == TICK_DIV - 1);
      if (sa) begin
`ifdef LAP_STOPWATCH_LAP_DELTA_EN
        v = (m_cnt - m_ref + MOD) % MOD;
        m_ref = m_cnt;
`else
        v = m_cnt;
`endif
        m_q.push_back(v);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
        m_sel = m_q.size() - 1;
      end else if (ns && m_q.size() > 0) begin
        m_sel = (m_sel == 0) ? m_q.size() - 1 : m_sel - 1;
      end
      if (ost == 1) begin
        m_pre = tk ? 0 : m_pre + 1;
        if (tk) m_cnt = (m_cnt + 1) % MOD;
      end
      if (tr) begin
        if (ost == 0)      m_st = 1;
        else if (ost == 1) begin m_st = 2; m_frz = 0; end
        else               m_st = 1;
      end else if (sp) begin
        if (ost == 1) begin m_snap = ocnt; m_frz = 1; end
        else if (ost == 2) begin m_st = 0; m_ref = 0; end
      end
      if (m_st == 0) begin m_cnt = 0; m_pre = 0; end
    end
    e.t = to_bcd(m_frz ? m_snap : m_cnt);
    e.s = (m_q.size() == 0) ? '0 : to_bcd(m_q[m_sel]);
    e.c = m_q.size();
    e.r = (m_st == 1);
    e.f = m_frz;
    sb.push_back(e);
  endtask

  task automatic cycle(input bit tr, input bit sp, input bit sa, input bit ns, input bit rn = 1'b1);
    bus.trig = tr; bus.split = sp; bus.sample = sa; bus.next_sample = ns;
    reset_n = rn;
    @(posedge clk);
    model_step(tr, sp, sa, ns, rn);
    @(negedge clk);
    bus.trig = 1'b0; bus.split = 1'b0; bus.sample = 1'b0; bus.next_sample = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  task automatic run_to(input int v);
    int guard = 0;
    while (m_cnt != v && guard < 1000) begin
      cycle(0, 0, 0, 0);
      guard++;
    end
    if (guard >= 1000) check("run_to_timeout", guard, 0);
  endtask

  // Scoreboard: every clocked cycle's prediction is compared here.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_time_out",  bus.time_out,  e.t);
      check("sb_stash_out", bus.stash_out, e.s);
      check("sb_stash_cnt", bus.stash_cnt, e.c);
      check("sb_running",   bus.running,   e.r);
      check("sb_frozen",    bus.frozen,    e.f);
    end
  end

  initial begin
    bus.trig = 0; bus.split = 0; bus.sample = 0; bus.next_sample = 0;
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("rst_time_out", bus.time_out, 0);
    check("rst_stash_cnt", bus.stash_cnt, 0);
    check("rst_running", bus.running, 0);

    // start, run, pause, clear
    cycle(1, 0, 0, 0);
    idle(40);
    check("run40_time", bus.time_out, 8'h20);
    check("run40_running", bus.running, 1);
    cycle(1, 0, 0, 0);
    idle(20);
    check("pause_hold", bus.time_out, 8'h20);
    check("pause_running", bus.running, 0);
    cycle(0, 1, 0, 0);
    check("clear_time", bus.time_out, 8'h00);
    cycle(0, 1, 0, 0);
    check("idle_split_frozen", bus.frozen, 0);
    cycle(1, 1, 0, 0);
    check("trig_wins_running", bus.running, 1);
    check("trig_wins_frozen", bus.frozen, 0);

    // wrap from 95
    run_to(95);
    check("at95", bus.time_out, 8'h95);
    idle(20);
    check("wrap_05", bus.time_out, 8'h05);

    // split snapshots
    run_to(7);
    cycle(0, 1, 0, 0);
    check("split07_frozen", bus.frozen, 1);
    check("split07_time", bus.time_out, 8'h07);
    run_to(12);
    cycle(0, 1, 0, 0);
    check("split12_time", bus.time_out, 8'h12);
    idle(3);
    check("split12_hold", bus.time_out, 8'h12);
    cycle(1, 0, 0, 0);
    check("unfreeze_frozen", bus.frozen, 0);
    check("unfreeze_live", bus.time_out, to_bcd(m_cnt));

    // stash fill and browse
    idle(0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    run_to(5);  cycle(0, 0, 1, 0);
    run_to(10); cycle(0, 0, 1, 0);
    run_to(15); cycle(0, 0, 1, 0);
    run_to(20); cycle(0, 0, 1, 0);
    check("stash_full_cnt", bus.stash_cnt, 3);
`ifndef LAP_STOPWATCH_LAP_DELTA_EN
    check("stash_newest", bus.stash_out, 8'h20);
    cycle(0, 0, 0, 1); check("browse1", bus.stash_out, 8'h15);
    cycle(0, 0, 0, 1); check("browse2", bus.stash_out, 8'h10);
    cycle(0, 0, 0, 1); check("browse3", bus.stash_out, 8'h20);
    run_to(33);
    cycle(0, 0, 1, 1);
    check("sample_beats_next", bus.stash_out, 8'h33);
`endif
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check("empty_next_out", bus.stash_out, 8'h00);
    check("empty_next_cnt", bus.stash_cnt, 0);

`ifdef LAP_STOPWATCH_LAP_DELTA_EN
    cycle(1, 0, 0, 0);
    run_to(12); cycle(0, 0, 1, 0);
    check("delta_first", bus.stash_out, 8'h12);
    run_to(30); cycle(0, 0, 1, 0);
    check("delta_second", bus.stash_out, 8'h18);
    cycle(0, 0, 0, 1);
    check("delta_browse", bus.stash_out, 8'h12);
`endif

    // random pulses, occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 199) != 0);
    end

    // reset mid-count
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    idle(7);
    cycle(0, 0, 1, 0);
    idle(3);
    cycle(0, 0, 0, 0, 0);
    check("midrst_time", bus.time_out, 0);
    check("midrst_stash_out", bus.stash_out, 0);
    check("midrst_stash_cnt", bus.stash_cnt, 0);
    check("midrst_running", bus.running, 0);
    check("midrst_frozen", bus.frozen, 0);

    repeat (2) @(posedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
